// File: rtl/ctrl_pkg.sv
// Shared decode constants for the ID-stage control unit: opcodes, base control encodings, bubble.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_MUL   = 6'b011100;

  // Minimum-width encodings; the decoder zero-extends to the configured widths.
  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
  } ctrl_t;

  localparam ctrl_t CTRL_RTYPE  = '{wb: 2'b10, mem: 3'b000, ex: 4'b0010};
  localparam ctrl_t CTRL_LW     = '{wb: 2'b01, mem: 3'b001, ex: 4'b0010};
  localparam ctrl_t CTRL_SW     = '{wb: 2'b00, mem: 3'b010, ex: 4'b0010};
  localparam ctrl_t CTRL_BEQ    = '{wb: 2'b00, mem: 3'b100, ex: 4'b0110};
  localparam ctrl_t CTRL_ADDI   = '{wb: 2'b10, mem: 3'b000, ex: 4'b0011};
  localparam ctrl_t CTRL_MUL    = '{wb: 2'b10, mem: 3'b000, ex: 4'b1000};
  localparam ctrl_t CTRL_BUBBLE = '{wb: 2'b00, mem: 3'b000, ex: 4'b0000};

  // Opcodes whose rt field is a source operand (ADDI and LW write rt instead).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode -> WB/MEM/EX control decode; purely combinational, no backpressure.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int WBW  = 2,
  parameter int MEMW = 3,
  parameter int EXW  = 4
) (
  input  logic [OPW-1:0]  opcode,
  output logic [WBW-1:0]  wb,
  output logic [MEMW-1:0] mem,
  output logic [EXW-1:0]  ex,
  output logic            illegal,
  output logic            is_lw,
  output logic            is_mul
);

  ctrl_t dec;

  always_comb begin
    dec     = CTRL_BUBBLE;
    illegal = 1'b0;
    is_lw   = 1'b0;
    is_mul  = 1'b0;
    case (6'(opcode))
      OP_RTYPE: dec = CTRL_RTYPE;
      OP_LW: begin
        dec   = CTRL_LW;
        is_lw = 1'b1;
      end
      OP_SW:   dec = CTRL_SW;
      OP_BEQ:  dec = CTRL_BEQ;
      OP_ADDI: dec = CTRL_ADDI;
      OP_MUL: begin
        dec    = CTRL_MUL;
        is_mul = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign wb  = WBW'(dec.wb);
  assign mem = MEMW'(dec.mem);
  assign ex  = EXW'(dec.ex);

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX control slice: 1-cycle decode register with load-use and MUL-occupancy hazards.
// Stall is combinational and holds PC/IF-ID; a stalled or flushed slot issues a bubble.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int OPW      = 6,
  parameter int REGW     = 5,
  parameter int WBW      = 2,
  parameter int MEMW     = 3,
  parameter int EXW      = 4,
  parameter int MULT_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] rs,
  input  logic [REGW-1:0] rt,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  output logic [WBW-1:0]  wb_q,
  output logic [MEMW-1:0] mem_q,
  output logic [EXW-1:0]  ex_q,
  output logic            illegal_q
);

  localparam int CW = $clog2(MULT_LAT) + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [WBW-1:0]  dec_wb;
  logic [MEMW-1:0] dec_mem;
  logic [EXW-1:0]  dec_ex;
  logic            dec_illegal, dec_is_lw, dec_is_mul;

  logic [0:0]      state;
  logic [CW-1:0]   cnt, cnt_dec, cnt_nxt;
  logic            ld_pending;
  logic [REGW-1:0] ld_dest;
  logic            lu, busy, issue;

  ctrl_decode #(.OPW(OPW), .WBW(WBW), .MEMW(MEMW), .EXW(EXW)) u_decode (
    .opcode  (opcode),
    .wb      (dec_wb),
    .mem     (dec_mem),
    .ex      (dec_ex),
    .illegal (dec_illegal),
    .is_lw   (dec_is_lw),
    .is_mul  (dec_is_mul)
  );

  assign lu = in_valid && ld_pending && (ld_dest != '0) &&
              ((ld_dest == rs) || ((ld_dest == rt) && uses_rt(6'(opcode))));
  assign busy  = (state == ST_BUSY);
  assign stall = in_valid && (lu || busy) && !flush;
  assign issue = in_valid && !flush && !stall;

  // Saturating decrement: the counter idles at zero rather than wrapping.
  assign cnt_dec = (cnt != '0) ? cnt - CW'(1) : cnt;

  always_comb begin
    cnt_nxt = cnt_dec;
    if (flush)
      cnt_nxt = '0;
    else if (issue && dec_is_mul)
      cnt_nxt = CW'(MULT_LAT - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ld_pending <= 1'b0;
      ld_dest    <= '0;
      out_valid  <= 1'b0;
      wb_q       <= '0;
      mem_q      <= '0;
      ex_q       <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state      <= (cnt_nxt != '0) ? ST_BUSY : ST_IDLE;
      cnt        <= cnt_nxt;
      ld_pending <= issue && dec_is_lw;
      if (issue) begin
        ld_dest   <= rt;
        out_valid <= 1'b1;
        wb_q      <= dec_wb;
        mem_q     <= dec_mem;
        ex_q      <= dec_ex;
        illegal_q <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
        wb_q      <= WBW'(CTRL_BUBBLE.wb);
        mem_q     <= MEMW'(CTRL_BUBBLE.mem);
        ex_q      <= EXW'(CTRL_BUBBLE.ex);
        illegal_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed scoreboard bench for ctrl_pipe_unit (MULT_LAT=4).
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] opcode;
  logic [4:0] rs, rt;
  logic       flush;
  logic       stall, out_valid, illegal_q;
  logic [1:0] wb_q;
  logic [2:0] mem_q;
  logic [3:0] ex_q;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       v;
    logic [1:0] wb;
    logic [2:0] mem;
    logic [3:0] ex;
    logic       ill;
  } exp_t;

  exp_t sb[$];

  localparam exp_t E_BUB  = '{v: 1'b0, wb: 2'b00, mem: 3'b000, ex: 4'b0000, ill: 1'b0};
  localparam exp_t E_R    = '{v: 1'b1, wb: 2'b10, mem: 3'b000, ex: 4'b0010, ill: 1'b0};
  localparam exp_t E_LW   = '{v: 1'b1, wb: 2'b01, mem: 3'b001, ex: 4'b0010, ill: 1'b0};
  localparam exp_t E_SW   = '{v: 1'b1, wb: 2'b00, mem: 3'b010, ex: 4'b0010, ill: 1'b0};
  localparam exp_t E_BEQ  = '{v: 1'b1, wb: 2'b00, mem: 3'b100, ex: 4'b0110, ill: 1'b0};
  localparam exp_t E_ADDI = '{v: 1'b1, wb: 2'b10, mem: 3'b000, ex: 4'b0011, ill: 1'b0};
  localparam exp_t E_MUL  = '{v: 1'b1, wb: 2'b10, mem: 3'b000, ex: 4'b1000, ill: 1'b0};
  localparam exp_t E_ILL  = '{v: 1'b1, wb: 2'b00, mem: 3'b000, ex: 4'b0000, ill: 1'b1};

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, MUL = 6'b011100, BAD = 6'b111111;

  ctrl_pipe_unit #(.MULT_LAT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .rs        (rs),
    .rt        (rt),
    .flush     (flush),
    .stall     (stall),
    .out_valid (out_valid),
    .wb_q      (wb_q),
    .mem_q     (mem_q),
    .ex_q      (ex_q),
    .illegal_q (illegal_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t, input logic fl);
    in_valid = iv;
    opcode   = op;
    rs       = s;
    rt       = t;
    flush    = fl;
    #1;
  endtask

  // Check combinational stall, queue the expected ID/EX slot, clock once and compare.
  task automatic step(input string tag, input logic exp_stall, input exp_t e);
    exp_t got;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(got.v));
    chk({tag, ".wb_q"},      32'(wb_q),      32'(got.wb));
    chk({tag, ".mem_q"},     32'(mem_q),     32'(got.mem));
    chk({tag, ".ex_q"},      32'(ex_q),      32'(got.ex));
    chk({tag, ".illegal_q"}, 32'(illegal_q), 32'(got.ill));
    @(negedge clk);
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".wb_q"},      32'(wb_q),      32'd0);
    chk({tag, ".mem_q"},     32'(mem_q),     32'd0);
    chk({tag, ".ex_q"},      32'(ex_q),      32'd0);
    chk({tag, ".illegal_q"}, 32'(illegal_q), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, RT, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk_zero_out("reset");
    chk("reset.cnt", 32'(dut.cnt), 32'd0);
    chk("reset.ld_pending", 32'(dut.ld_pending), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Async reset mid-hazard: outputs clear with no clock edge
    drive(1'b1, RT, 5'd1, 5'd2, 1'b0);  step("r0", 1'b0, E_R);
    drive(1'b1, LW, 5'd1, 5'd5, 1'b0);  step("lw0", 1'b0, E_LW);
    drive(1'b1, RT, 5'd5, 5'd6, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero_out("async_rst");
    chk("async_rst.ld_pending", 32'(dut.ld_pending), 32'd0);
    chk("async_rst.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, RT, 5'd3, 5'd4, 1'b0);  step("r_after_rst", 1'b0, E_R);

    // Load-use on rs: one stall, one bubble, then issue
    drive(1'b1, LW, 5'd0, 5'd5, 1'b0);  step("lu.lw", 1'b0, E_LW);
    drive(1'b1, RT, 5'd5, 5'd6, 1'b0);  step("lu.stall", 1'b1, E_BUB);
    step("lu.issue", 1'b0, E_R);

    // No false hazards: r0 destination, and ADDI does not read rt
    drive(1'b1, LW, 5'd1, 5'd0, 1'b0);  step("nh.lw0", 1'b0, E_LW);
    drive(1'b1, RT, 5'd0, 5'd0, 1'b0);  step("nh.add0", 1'b0, E_R);
    drive(1'b1, LW, 5'd1, 5'd7, 1'b0);  step("nh.lw7", 1'b0, E_LW);
    drive(1'b1, ADDI, 5'd1, 5'd7, 1'b0); step("nh.addi", 1'b0, E_ADDI);

    // Load-use through rt of a BEQ, then SW
    drive(1'b1, LW, 5'd2, 5'd8, 1'b0);  step("lu_rt.lw", 1'b0, E_LW);
    drive(1'b1, BEQ, 5'd1, 5'd8, 1'b0); step("lu_rt.stall", 1'b1, E_BUB);
    step("lu_rt.beq", 1'b0, E_BEQ);
    drive(1'b1, SW, 5'd1, 5'd8, 1'b0);  step("sw", 1'b0, E_SW);

    // MUL occupancy: exactly MULT_LAT-1 = 3 stall cycles
    drive(1'b1, MUL, 5'd1, 5'd2, 1'b0); step("mul.issue", 1'b0, E_MUL);
    chk("mul.cnt", 32'(dut.cnt), 32'd3);
    drive(1'b1, RT, 5'd9, 5'd10, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("mul.stall%0d", i), 1'b1, E_BUB);
    step("mul.next", 1'b0, E_R);

    // Busy countdown with nothing waiting: no stall
    drive(1'b1, MUL, 5'd1, 5'd2, 1'b0); step("mul2.issue", 1'b0, E_MUL);
    drive(1'b0, RT, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) step($sformatf("mul2.idle%0d", i), 1'b0, E_BUB);
    chk("mul2.cnt", 32'(dut.cnt), 32'd0);

    // Flush aborts MUL occupancy at cnt=2
    drive(1'b1, MUL, 5'd1, 5'd2, 1'b0); step("fl.mul", 1'b0, E_MUL);
    drive(1'b1, RT, 5'd3, 5'd4, 1'b0);  step("fl.stall", 1'b1, E_BUB);
    chk("fl.cnt2", 32'(dut.cnt), 32'd2);
    drive(1'b1, RT, 5'd3, 5'd4, 1'b1);  step("fl.flush", 1'b0, E_BUB);
    chk("fl.cnt0", 32'(dut.cnt), 32'd0);
    drive(1'b1, RT, 5'd3, 5'd4, 1'b0);  step("fl.after", 1'b0, E_R);

    // Flush beats a load-use hazard and clears the pending load
    drive(1'b1, LW, 5'd0, 5'd5, 1'b0);  step("flu.lw", 1'b0, E_LW);
    drive(1'b1, RT, 5'd5, 5'd1, 1'b1);  step("flu.flush", 1'b0, E_BUB);
    drive(1'b1, RT, 5'd5, 5'd1, 1'b0);  step("flu.add", 1'b0, E_R);

    // Reset during MUL occupancy
    drive(1'b1, MUL, 5'd1, 5'd2, 1'b0); step("rm.mul", 1'b0, E_MUL);
    drive(1'b1, RT, 5'd3, 5'd4, 1'b0);
    rst = 1'b1;
    #1;
    chk("rm.cnt", 32'(dut.cnt), 32'd0);
    chk("rm.stall", 32'(stall), 32'd0);
    chk_zero_out("rm");
    @(negedge clk);
    rst = 1'b0;
    step("rm.after", 1'b0, E_R);

    // Illegal opcode, then a legal one clears illegal_q
    drive(1'b1, BAD, 5'd1, 5'd2, 1'b0);  step("ill", 1'b0, E_ILL);
    drive(1'b1, ADDI, 5'd1, 5'd2, 1'b0); step("ill.clear", 1'b0, E_ADDI);

    chk("sb.empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
